// File: rtl/pipelined_adder_unit_if.sv
// Operand/result bus of the multi-cycle adder/subtractor.
//   SW, LoadA, LoadB   operand source and level-sensitive load enables
//   Run, Sub, Accum    start request (edge-detected in the unit), op select, write-back select
//   A, B               operand registers, exported for display
//   Sum, CO, OV        result of the last completed operation
//   Busy, Done         operation in progress / one-cycle completion pulse
interface pipelined_adder_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] SW;
    logic             LoadA;
    logic             LoadB;
    logic             Run;
    logic             Sub;
    logic             Accum;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Sum;
    logic             CO;
    logic             OV;
    logic             Busy;
    logic             Done;

    // Requester side: drives operands and control, observes results.
    modport master (
        output SW, LoadA, LoadB, Run, Sub, Accum,
        input  A, B, Sum, CO, OV, Busy, Done
    );

    // Adder unit side.
    modport slave (
        input  SW, LoadA, LoadB, Run, Sub, Accum,
        output A, B, Sum, CO, OV, Busy, Done
    );
endinterface

// File: rtl/pipelined_adder_unit.sv
// Multi-cycle adder/subtractor: A and B are loaded from SW, a rising edge on
// Run launches A+B or A-B, processed as STAGES carry-chained slices of
// WIDTH/STAGES bits, one slice per clock. Reports Sum, CO and OV, pulses Done,
// and optionally writes Sum back into A (accumulate).
//   Clk    rising-edge clock
//   Reset  asynchronous, active-high; clears all state
//   bus    pipelined_adder_unit_if slave modport (operands, control, results)
module pipelined_adder_unit #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    pipelined_adder_unit_if.slave  bus
);

    localparam int unsigned SLW  = WIDTH / STAGES;
    localparam int unsigned SLW1 = SLW + 1;
    localparam int unsigned KW   = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state;
    logic             run_q;
    logic             accum_q;
    logic             c;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] aw;
    logic [WIDTH-1:0] bw;
    logic [WIDTH-1:0] part;

    logic             start;
    logic             last;
    logic [SLW:0]     slice_sum;
    logic [WIDTH-1:0] part_next;
    logic             ov_next;

    assign start = bus.Run && !run_q && !bus.Busy;
    assign last  = (k == KW'(STAGES - 1));

    // Working copies shift right one slice per cycle, so the active slice is
    // always the low SLW bits.
    assign slice_sum = SLW1'(aw[SLW-1:0]) + SLW1'(bw[SLW-1:0]) + SLW1'(c);

    // Completed slices enter at the top; after STAGES shifts the word is whole.
    assign part_next = (part >> SLW) | (WIDTH'(slice_sum[SLW-1:0]) << (WIDTH - SLW));

    // Carry into the MSB is a ^ b ^ s at that bit; XOR with carry out gives OV.
    assign ov_next = aw[SLW-1] ^ bw[SLW-1] ^ slice_sum[SLW-1] ^ slice_sum[SLW];

    // Control FSM, operand registers and slice datapath.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            run_q    <= 1'b0;
            accum_q  <= 1'b0;
            c        <= 1'b0;
            k        <= '0;
            aw       <= '0;
            bw       <= '0;
            part     <= '0;
            bus.A    <= '0;
            bus.B    <= '0;
            bus.Sum  <= '0;
            bus.CO   <= 1'b0;
            bus.OV   <= 1'b0;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b0;
        end else begin
            run_q    <= bus.Run;
            bus.Done <= 1'b0;

            if (!bus.Busy) begin
                if (bus.LoadA) bus.A <= bus.SW;
                if (bus.LoadB) bus.B <= bus.SW;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        aw       <= bus.A;
                        bw       <= bus.Sub ? ~bus.B : bus.B;
                        c        <= bus.Sub;
                        accum_q  <= bus.Accum;
                        k        <= '0;
                        bus.Busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    aw   <= aw >> SLW;
                    bw   <= bw >> SLW;
                    c    <= slice_sum[SLW];
                    part <= part_next;
                    k    <= k + KW'(1);
                    if (last) begin
                        bus.Sum  <= part_next;
                        bus.CO   <= slice_sum[SLW];
                        bus.OV   <= ov_next;
                        bus.Done <= 1'b1;
                        bus.Busy <= 1'b0;
                        state    <= IDLE;
                        // Write-back overrides any LoadA, which is blocked while Busy.
                        if (accum_q) bus.A <= part_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
